perceptron_uart_core: RTL and testbench

PERCEPTRON_UART_CORE -- requirements
Module: perceptron_uart_core

---
 rtl/perceptron_uart_core.sv | 140 ++++++++++++++
 tb/tb_perceptron_uart_core.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_uart_core.sv
// Byte-stream perceptron: 'W' loads signed weights, 'X' loads unsigned inputs and
// triggers a serial multiply-accumulate whose activation and sum are replied as ASCII.
module perceptron_uart_core #(
    parameter int N_INPUTS = 4,
    parameter int ACC_WIDTH = 20,
    parameter logic signed [ACC_WIDTH-1:0] BIAS = '0,
    parameter logic signed [ACC_WIDTH-1:0] THRESHOLD = '0,
    parameter int HEX_SUM = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_full,
    output logic       busy,
    output logic       fire,
    output logic       overrun
);

    localparam int NUM_DIGITS = (HEX_SUM != 0) ? ACC_WIDTH / 4 : 0;
    localparam int NUM_BYTES = NUM_DIGITS + 3;
    localparam int MAX_CNT = (N_INPUTS > NUM_BYTES) ? N_INPUTS : NUM_BYTES;
    localparam int CNT_W = $clog2(MAX_CNT);
    localparam int IDX_W = $clog2(N_INPUTS);
    localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, MAC, SEND} state_t;

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic signed [7:0] weights [N_INPUTS];
    logic [7:0] inputs [N_INPUTS];
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [16:0] product;
    logic [3:0] nibble;
    logic [7:0] reply_byte;

    assign idx = cnt[IDX_W-1:0];

    always_comb begin
        product = weights[idx] * $signed({1'b0, inputs[idx]});
        acc_sum = acc + ACC_WIDTH'(product);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == 8'h57) begin
                    state_next = LOAD_W;
                end else if (rx_valid && rx_data == 8'h58) begin
                    state_next = LOAD_X;
                end
            end
            LOAD_W: if (rx_valid && cnt == LAST_IN) state_next = IDLE;
            LOAD_X: if (rx_valid && cnt == LAST_IN) state_next = MAC;
            MAC:    if (cnt == LAST_IN) state_next = SEND;
            SEND:   if (!tx_full && cnt == LAST_BYTE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reply byte order: activation digit, hex digits of acc MSB first, CR, LF.
    always_comb begin
        nibble = 4'h0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (int'(cnt) == NUM_DIGITS - d) nibble = acc[4*d +: 4];
        end
        if (cnt == '0) begin
            reply_byte = fire ? 8'h31 : 8'h30;
        end else if (int'(cnt) <= NUM_DIGITS) begin
            reply_byte = (nibble < 4'd10) ? 8'h30 + {4'h0, nibble} : 8'h37 + {4'h0, nibble};
        end else if (int'(cnt) == NUM_DIGITS + 1) begin
            reply_byte = 8'h0D;
        end else begin
            reply_byte = 8'h0A;
        end
        busy = (state == MAC) || (state == SEND);
        tx_write = (state == SEND) && !tx_full;
        tx_data = tx_write ? reply_byte : 8'h00;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            acc <= '0;
            fire <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                weights[i] <= '0;
                inputs[i] <= '0;
            end
        end else begin
            overrun <= rx_valid && ((state == MAC) || (state == SEND));
            case (state)
                IDLE: cnt <= '0;
                LOAD_W: begin
                    if (rx_valid) begin
                        weights[idx] <= $signed(rx_data);
                        cnt <= (cnt == LAST_IN) ? '0 : cnt + CNT_W'(1);
                    end
                end
                LOAD_X: begin
                    if (rx_valid) begin
                        inputs[idx] <= rx_data;
                        cnt <= (cnt == LAST_IN) ? '0 : cnt + CNT_W'(1);
                        if (cnt == LAST_IN) acc <= BIAS;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (cnt == LAST_IN) begin
                        cnt <= '0;
                        fire <= (acc_sum >= THRESHOLD);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (!tx_full) cnt <= (cnt == LAST_BYTE) ? '0 : cnt + CNT_W'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_uart_core.sv
// Scoreboard bench for perceptron_uart_core: a behavioural model queues the expected
// reply bytes, and every tx_write pops and compares one of them.
module tb_perceptron_uart_core;

    localparam int N = 4;
    localparam int AW = 20;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_full = 1'b0;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       busy;
    logic       fire;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int first_tx_cyc = -1;
    int last_x_cyc = 0;
    int tx_count = 0;
    int ovr_count = 0;
    int model_w [N];
    logic exp_fire = 1'b0;
    logic [7:0] expq [$];

    always #5 CLK = ~CLK;

    perceptron_uart_core #(
        .N_INPUTS(N),
        .ACC_WIDTH(AW),
        .BIAS('0),
        .THRESHOLD('0),
        .HEX_SUM(1)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_write(tx_write),
        .tx_full(tx_full),
        .busy(busy),
        .fire(fire),
        .overrun(overrun)
    );

    // One clock cycle; transmit activity is sampled on the falling edge.
    task automatic tick();
        logic [7:0] exp_b;
        @(negedge CLK);
        if (tx_write === 1'b1) begin
            tx_count++;
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            vectors++;
            if (tx_full !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL tx_write_while_full got tx_full=%b want 0", tx_full);
            end
            vectors++;
            if (expq.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_tx got %h want no byte", tx_data);
            end else begin
                exp_b = expq.pop_front();
                if (tx_data !== exp_b) begin
                    miscompares++;
                    $display("[TB] FAIL tx_byte got %h want %h", tx_data, exp_b);
                end
            end
        end
        if (overrun === 1'b1) ovr_count++;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic push_reply(input int sum);
        logic [AW-1:0] a;
        logic [3:0] nib;
        a = sum[AW-1:0];
        exp_fire = ($signed(a) >= 0);
        expq.push_back(exp_fire ? 8'h31 : 8'h30);
        for (int d = AW / 4 - 1; d >= 0; d--) begin
            nib = a[4*d +: 4];
            expq.push_back((nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib});
        end
        expq.push_back(8'h0D);
        expq.push_back(8'h0A);
    endtask

    task automatic load_weights(input logic [8*N-1:0] wv);
        logic [7:0] b;
        send_byte(8'h57);
        for (int i = 0; i < N; i++) begin
            b = wv[8*(N-1-i) +: 8];
            model_w[i] = int'($signed(b));
            send_byte(b);
        end
    endtask

    task automatic send_inputs(input logic [8*N-1:0] xv);
        logic [7:0] b;
        int sum;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            b = xv[8*(N-1-i) +: 8];
            sum += model_w[i] * int'(b);
        end
        push_reply(sum);
        first_tx_cyc = -1;
        send_byte(8'h58);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) last_x_cyc = cyc;
            send_byte(xv[8*(N-1-i) +: 8]);
        end
    endtask

    task automatic wait_reply(input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++) tick();
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reply_timeout got %0d bytes left want 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic wait_tx_count(input int target, input int budget);
        for (int i = 0; i < budget && tx_count < target; i++) tick();
        vectors++;
        if (tx_count < target) begin
            miscompares++;
            $display("[TB] FAIL tx_count_timeout got %0d want %0d", tx_count, target);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        tick();
        vectors++;
        if (tx_write !== 1'b0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_tx got write=%b data=%h want 0/00", tx_write, tx_data);
        end
        vectors++;
        if (busy !== 1'b0 || fire !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags got busy=%b fire=%b ovr=%b want 000", busy, fire, overrun);
        end
        RST_N = 1'b1;
        for (int i = 0; i < N; i++) model_w[i] = 0;
        tick();
    endtask

    task automatic test_default();
        load_weights(32'h01020304);
        send_inputs(32'h01010101);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mac_busy got %b want 1", busy);
        end
        wait_reply(40);
        vectors++;
        if (first_tx_cyc - last_x_cyc != N + 1) begin
            miscompares++;
            $display("[TB] FAIL latency got %0d want %0d", first_tx_cyc - last_x_cyc, N + 1);
        end
        vectors++;
        if (fire !== exp_fire) begin
            miscompares++;
            $display("[TB] FAIL default_fire got %b want %b", fire, exp_fire);
        end
    endtask

    task automatic test_negative();
        load_weights(32'hFFFFFFFF);
        send_inputs(32'h10101010);
        wait_reply(40);
        vectors++;
        if (fire !== exp_fire) begin
            miscompares++;
            $display("[TB] FAIL negative_fire got %b want %b", fire, exp_fire);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int held;
        load_weights(32'h01020304);
        base = tx_count;
        send_inputs(32'h01010101);
        wait_tx_count(base + 2, 30);
        tx_full = 1'b1;
        held = tx_count;
        repeat (5) tick();
        vectors++;
        if (tx_count != held) begin
            miscompares++;
            $display("[TB] FAIL stall_writes got %0d want 0", tx_count - held);
        end
        tx_full = 1'b0;
        wait_reply(40);
        vectors++;
        if (tx_count - base != 8) begin
            miscompares++;
            $display("[TB] FAIL stall_total got %0d want 8", tx_count - base);
        end
    endtask

    task automatic test_overrun();
        int ovr0;
        int tx0;
        ovr0 = ovr_count;
        send_inputs(32'h01010101);
        send_byte(8'h55);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overrun_pulse got %b want 1", overrun);
        end
        wait_reply(40);
        vectors++;
        if (ovr_count - ovr0 != 1) begin
            miscompares++;
            $display("[TB] FAIL overrun_count got %0d want 1", ovr_count - ovr0);
        end
        tx0 = tx_count;
        send_byte(8'h41);
        repeat (3) tick();
        vectors++;
        if (ovr_count - ovr0 != 1 || tx_count != tx0) begin
            miscompares++;
            $display("[TB] FAIL idle_ignore got ovr=%0d tx=%0d want 1/0", ovr_count - ovr0, tx_count - tx0);
        end
    endtask

    task automatic test_last_byte_overrun();
        send_inputs(32'h01010101);
        repeat (N + 7) tick();
        send_byte(8'h57);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL last_byte_overrun got %b want 1", overrun);
        end
        wait_reply(10);
        send_inputs(32'h02020202);
        wait_reply(40);
    endtask

    task automatic test_abort();
        int tx0;
        tx0 = tx_count;
        send_inputs(32'h01010101);
        wait_tx_count(tx0 + 3, 30);
        RST_N = 1'b0;
        #1;
        vectors++;
        if (tx_write !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || fire !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got w=%b d=%h b=%b f=%b o=%b want all 0",
                     tx_write, tx_data, busy, fire, overrun);
        end
        expq.delete();
        for (int i = 0; i < N; i++) model_w[i] = 0;
        tx0 = tx_count;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();
        vectors++;
        if (tx_count != tx0) begin
            miscompares++;
            $display("[TB] FAIL abort_writes got %0d want 0", tx_count - tx0);
        end
        send_inputs(32'h01010101);
        wait_reply(40);
        vectors++;
        if (fire !== exp_fire) begin
            miscompares++;
            $display("[TB] FAIL cleared_fire got %b want %b", fire, exp_fire);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_negative();
        test_backpressure();
        test_overrun();
        test_last_byte_overrun();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
